id_issue_stage: RTL and testbench

- Instruction decode and issue stage of the 5-stage MIPS pipeline. It is the producer side of the EX-stage ALU interface.
- Accepts 32-bit instructions over a valid/ready handshake.
- Splits each instruction into opcode, func, shamt, immediate and address fields, reads operands from an internal 32x32 register file, and generates the 8-bit control_EX word.
- Registers everything into the ID/EX output register. Load-use hazards are handled by inserting bubbles.

---
 rtl/id_issue_stage_if.sv | 35 +++
 rtl/id_issue_stage.sv | 205 ++++++++++++++++++++
 tb/tb_id_issue_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_stage_if.sv
// rtl/id_issue_stage_if.sv - fetch, write-back and ID/EX signal bundle for the decode/issue stage
interface id_issue_stage_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [4:0]  dest;
    logic [7:0]  control_EX;
    logic [31:0] pc_out;
    logic        illegal;

    modport slave (
        input  instr_valid, instr, instr_pc, wb_en, wb_addr, wb_data, ex_ready,
        output instr_ready, ex_valid, d1, d2, opcode, func, shamt, immediate,
               address, dest, control_EX, pc_out, illegal
    );

    modport master (
        output instr_valid, instr, instr_pc, wb_en, wb_addr, wb_data, ex_ready,
        input  instr_ready, ex_valid, d1, d2, opcode, func, shamt, immediate,
               address, dest, control_EX, pc_out, illegal
    );
endinterface

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - MIPS decode/issue stage with register file, ID/EX register and load-use stall
module id_issue_stage #(
    parameter int          HAZARD_BUBBLES = 1,
    parameter logic [31:0] RESET_PC_TAG   = 32'h0
) (
    input  logic            clock,
    input  logic            reset,
    id_issue_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [7:0] C_LINK = 8'h80;
    localparam logic [7:0] C_JUMP = 8'h40;
    localparam logic [7:0] C_IMM  = 8'h20;
    localparam logic [7:0] C_RDST = 8'h10;
    localparam logic [7:0] C_M2R  = 8'h08;
    localparam logic [7:0] C_MWR  = 8'h04;
    localparam logic [7:0] C_MRD  = 8'h02;
    localparam logic [7:0] C_RWR  = 8'h01;

    localparam logic [1:0] BUB_INIT = 2'(HAZARD_BUBBLES - 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t      state, state_nxt;
    logic [1:0]  bub_cnt, bub_cnt_nxt;
    logic [31:0] regs [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [7:0]  ctrl_dec;
    logic [4:0]  dest_dec;
    logic        ill_dec, rs_used, rt_used;
    logic [31:0] opa, opb;
    logic        hazard, load_en, ready, take;

    logic        valid_q, ill_q;
    logic [31:0] d1_q, d2_q, instr_q, pc_q;
    logic [7:0]  ctrl_q;
    logic [4:0]  dest_q;

    assign op = bus.instr[31:26];
    assign rs = bus.instr[25:21];
    assign rt = bus.instr[20:16];
    assign rd = bus.instr[15:11];
    assign sh = bus.instr[10:6];
    assign fn = bus.instr[5:0];

    always_comb begin
        ctrl_dec = 8'h00;
        dest_dec = 5'd0;
        ill_dec  = 1'b0;
        rs_used  = 1'b1;
        rt_used  = 1'b0;
        case (op)
            OP_RTYPE: begin
                rt_used = 1'b1;
                if (fn == 6'd0 && sh == 5'd0) begin
                    ctrl_dec = C_RDST;
                end else begin
                    ctrl_dec = C_RDST | C_RWR;
                    dest_dec = rd;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
                ctrl_dec = C_IMM | C_RWR;
                dest_dec = rt;
            end
            OP_LUI: begin
                ctrl_dec = C_IMM | C_RWR;
                dest_dec = rt;
                rs_used  = 1'b0;
            end
            OP_LW: begin
                ctrl_dec = C_IMM | C_M2R | C_MRD | C_RWR;
                dest_dec = rt;
            end
            OP_SW: begin
                ctrl_dec = C_IMM | C_MWR;
                rt_used  = 1'b1;
            end
            OP_J: begin
                ctrl_dec = C_JUMP;
                rs_used  = 1'b0;
            end
            OP_JAL: begin
                ctrl_dec = C_LINK | C_JUMP | C_RWR;
                dest_dec = 5'd31;
                rs_used  = 1'b0;
            end
            default: ill_dec = 1'b1;
        endcase
    end

    // Write-through: a same-cycle write-back is forwarded to the operand read
    always_comb begin
        opa = 32'h0;
        opb = 32'h0;
        if (rs != 5'd0)
            opa = (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : regs[rs];
        if (rt != 5'd0)
            opb = (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : regs[rt];
    end

    assign hazard  = bus.instr_valid && valid_q && ctrl_q[1] && (dest_q != 5'd0) &&
                     ((rs_used && rs == dest_q) || (rt_used && rt == dest_q));
    assign load_en = !valid_q || bus.ex_ready;
    assign ready   = reset && (state == RUN) && !hazard && load_en;
    assign take    = bus.instr_valid && ready;

    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        case (state)
            RUN: begin
                if (hazard && load_en) begin
                    bub_cnt_nxt = BUB_INIT;
                    if (BUB_INIT != 2'd0)
                        state_nxt = STALL;
                end
            end
            STALL: begin
                if (load_en) begin
                    bub_cnt_nxt = bub_cnt - 2'd1;
                    if (bub_cnt == 2'd1)
                        state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'h0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Without a transfer the load inserts a bubble; operand fields are left as they were
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            d1_q    <= 32'h0;
            d2_q    <= 32'h0;
            instr_q <= 32'h0;
            pc_q    <= RESET_PC_TAG;
            ctrl_q  <= 8'h00;
            dest_q  <= 5'd0;
        end else if (load_en) begin
            if (take) begin
                valid_q <= 1'b1;
                ill_q   <= ill_dec;
                d1_q    <= opa;
                d2_q    <= opb;
                instr_q <= bus.instr;
                pc_q    <= bus.instr_pc;
                ctrl_q  <= ctrl_dec;
                dest_q  <= dest_dec;
            end else begin
                valid_q <= 1'b0;
                ill_q   <= 1'b0;
                ctrl_q  <= 8'h00;
            end
        end
    end

    assign bus.instr_ready = ready;
    assign bus.ex_valid    = valid_q;
    assign bus.d1          = d1_q;
    assign bus.d2          = d2_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.func        = instr_q[5:0];
    assign bus.shamt       = instr_q[10:6];
    assign bus.immediate   = instr_q[15:0];
    assign bus.address     = instr_q[25:0];
    assign bus.dest        = dest_q;
    assign bus.control_EX  = ctrl_q;
    assign bus.pc_out      = pc_q;
    assign bus.illegal     = ill_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - directed scoreboard bench for id_issue_stage
module tb_id_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_issue_stage_if a_if ();
    id_issue_stage_if b_if ();

    id_issue_stage #(.HAZARD_BUBBLES(1), .RESET_PC_TAG(32'hBFC0_0000)) dut_a (
        .clock(clk), .reset(rst_n), .bus(a_if.slave)
    );
    id_issue_stage #(.HAZARD_BUBBLES(3), .RESET_PC_TAG(32'h0000_0A00)) dut_b (
        .clock(clk), .reset(rst_n), .bus(b_if.slave)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  dest;
        logic [7:0]  ctrl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [4:0] dest, input logic [7:0] ctrl, input logic ill);
        exp_t e;
        e.ins = ins; e.pc = pc; e.d1 = d1; e.d2 = d2;
        e.dest = dest; e.ctrl = ctrl; e.ill = ill;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        a_if.wb_en = 1'b1; a_if.wb_addr = addr; a_if.wb_data = data;
        tick();
        a_if.wb_en = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic exp_rdy, input exp_t e);
        a_if.instr_valid = 1'b1; a_if.instr = ins; a_if.instr_pc = pc;
        #1;
        check({tag, ".instr_ready"}, 32'(a_if.instr_ready), 32'(exp_rdy));
        if (exp_rdy) sb.push_back(e);
        tick();
        a_if.instr_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag);
        check({tag, ".ex_valid"}, 32'(a_if.ex_valid), 32'd1);
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL %s.scoreboard observed=output expected=no_output", tag);
        end
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check({tag, ".d1"},        a_if.d1, cur.d1);
            check({tag, ".d2"},        a_if.d2, cur.d2);
            check({tag, ".dest"},      32'(a_if.dest), 32'(cur.dest));
            check({tag, ".control"},   32'(a_if.control_EX), 32'(cur.ctrl));
            check({tag, ".opcode"},    32'(a_if.opcode), 32'(cur.ins[31:26]));
            check({tag, ".func"},      32'(a_if.func), 32'(cur.ins[5:0]));
            check({tag, ".shamt"},     32'(a_if.shamt), 32'(cur.ins[10:6]));
            check({tag, ".immediate"}, 32'(a_if.immediate), 32'(cur.ins[15:0]));
            check({tag, ".address"},   32'(a_if.address), 32'(cur.ins[25:0]));
            check({tag, ".pc_out"},    a_if.pc_out, cur.pc);
            check({tag, ".illegal"},   32'(a_if.illegal), 32'(cur.ill));
        end
    endtask

    initial begin
        logic       b_rdy [4];
        logic       b_val [4];
        a_if.instr_valid = 1'b0; a_if.instr = '0; a_if.instr_pc = '0;
        a_if.wb_en = 1'b0; a_if.wb_addr = '0; a_if.wb_data = '0; a_if.ex_ready = 1'b1;
        b_if.instr_valid = 1'b0; b_if.instr = '0; b_if.instr_pc = '0;
        b_if.wb_en = 1'b0; b_if.wb_addr = '0; b_if.wb_data = '0; b_if.ex_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();

        check("rst.ex_valid",    32'(a_if.ex_valid), 32'd0);
        check("rst.control",     32'(a_if.control_EX), 32'd0);
        check("rst.d1",          a_if.d1, 32'd0);
        check("rst.dest",        32'(a_if.dest), 32'd0);
        check("rst.pc_out",      a_if.pc_out, 32'hBFC0_0000);
        check("rst.illegal",     32'(a_if.illegal), 32'd0);
        check("rst.instr_ready", 32'(a_if.instr_ready), 32'd0);
        check("rst.b_pc_out",    b_if.pc_out, 32'h0000_0A00);

        rst_n = 1'b1;
        #1;
        check("idle.instr_ready", 32'(a_if.instr_ready), 32'd1);
        tick();
        check("idle.ex_valid", 32'(a_if.ex_valid), 32'd0);

        wb_write(5'd5, 32'h0000_0007);
        wb_write(5'd1, 32'h0000_0040);
        wb_write(5'd4, 32'h0000_1234);

        issue("add", 32'h00A51820, 32'h100, 1'b1, mk(32'h00A51820, 32'h100, 32'd7, 32'd7, 5'd3, 8'h11, 1'b0));
        expect_out("add");
        issue("sw", 32'hAC250004, 32'h104, 1'b1, mk(32'hAC250004, 32'h104, 32'h40, 32'd7, 5'd0, 8'h24, 1'b0));
        expect_out("sw");

        issue("lw", 32'h8C240008, 32'h108, 1'b1, mk(32'h8C240008, 32'h108, 32'h40, 32'h1234, 5'd4, 8'h2B, 1'b0));
        expect_out("lw");
        issue("add_hz", 32'h00841020, 32'h10C, 1'b0, mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h00, 1'b0));
        check("bubble.ex_valid", 32'(a_if.ex_valid), 32'd0);
        check("bubble.control",  32'(a_if.control_EX), 32'd0);
        issue("add_lu", 32'h00841020, 32'h10C, 1'b1, mk(32'h00841020, 32'h10C, 32'h1234, 32'h1234, 5'd2, 8'h11, 1'b0));
        expect_out("add_lu");

        issue("addi", 32'h20A60003, 32'h110, 1'b1, mk(32'h20A60003, 32'h110, 32'd7, 32'd0, 5'd6, 8'h21, 1'b0));
        expect_out("addi");
        a_if.ex_ready = 1'b0;
        a_if.instr_valid = 1'b1; a_if.instr = 32'h34A700F0; a_if.instr_pc = 32'h114;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hold.instr_ready", 32'(a_if.instr_ready), 32'd0);
            check("hold.ex_valid",    32'(a_if.ex_valid), 32'd1);
            check("hold.d1",          a_if.d1, cur.d1);
            check("hold.dest",        32'(a_if.dest), 32'(cur.dest));
            check("hold.control",     32'(a_if.control_EX), 32'(cur.ctrl));
            check("hold.pc_out",      a_if.pc_out, cur.pc);
            tick();
        end
        a_if.ex_ready = 1'b1;
        issue("ori", 32'h34A700F0, 32'h114, 1'b1, mk(32'h34A700F0, 32'h114, 32'd7, 32'd0, 5'd7, 8'h21, 1'b0));
        expect_out("ori");

        a_if.wb_en = 1'b1; a_if.wb_addr = 5'd9; a_if.wb_data = 32'hDEAD_BEEF;
        issue("byp", 32'h35280001, 32'h118, 1'b1, mk(32'h35280001, 32'h118, 32'hDEAD_BEEF, 32'd0, 5'd8, 8'h21, 1'b0));
        a_if.wb_en = 1'b0;
        expect_out("byp");
        issue("rd9", 32'h352B0000, 32'h11C, 1'b1, mk(32'h352B0000, 32'h11C, 32'hDEAD_BEEF, 32'd0, 5'd11, 8'h21, 1'b0));
        expect_out("rd9");
        a_if.wb_en = 1'b1; a_if.wb_addr = 5'd0; a_if.wb_data = 32'hFFFF_FFFF;
        issue("r0", 32'h340A0002, 32'h120, 1'b1, mk(32'h340A0002, 32'h120, 32'd0, 32'd0, 5'd10, 8'h21, 1'b0));
        a_if.wb_en = 1'b0;
        expect_out("r0");

        issue("jal", 32'h0C000040, 32'h124, 1'b1, mk(32'h0C000040, 32'h124, 32'd0, 32'd0, 5'd31, 8'hC1, 1'b0));
        expect_out("jal");
        issue("ill", 32'hFC000000, 32'h128, 1'b1, mk(32'hFC000000, 32'h128, 32'd0, 32'd0, 5'd0, 8'h00, 1'b1));
        expect_out("ill");
        issue("j", 32'h08000010, 32'h12C, 1'b1, mk(32'h08000010, 32'h12C, 32'd0, 32'd0, 5'd0, 8'h40, 1'b0));
        expect_out("j");
        issue("lw13", 32'h8C0D0000, 32'h130, 1'b1, mk(32'h8C0D0000, 32'h130, 32'd0, 32'd0, 5'd13, 8'h2B, 1'b0));
        expect_out("lw13");
        issue("lui", 32'h3DACABCD, 32'h134, 1'b1, mk(32'h3DACABCD, 32'h134, 32'd0, 32'd0, 5'd12, 8'h21, 1'b0));
        expect_out("lui");

        b_if.instr_valid = 1'b1; b_if.instr = 32'h8C040000; b_if.instr_pc = 32'h200;
        #1;
        check("b.lw.instr_ready", 32'(b_if.instr_ready), 32'd1);
        tick();
        b_if.instr = 32'h00841020; b_if.instr_pc = 32'h204;
        b_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        b_val = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("b.stall.instr_ready", 32'(b_if.instr_ready), 32'(b_rdy[i]));
            check("b.stall.ex_valid",    32'(b_if.ex_valid), 32'(b_val[i]));
            tick();
        end
        check("b.add.ex_valid", 32'(b_if.ex_valid), 32'd1);
        check("b.add.dest",     32'(b_if.dest), 32'd2);
        check("b.add.control",  32'(b_if.control_EX), 32'h11);
        check("b.add.pc_out",   b_if.pc_out, 32'h204);

        b_if.instr = 32'h8C040000; b_if.instr_pc = 32'h208;
        tick();
        b_if.instr = 32'h00841020; b_if.instr_pc = 32'h20C;
        tick();
        #1;
        check("b.stall2.instr_ready", 32'(b_if.instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("b.rst.ex_valid", 32'(b_if.ex_valid), 32'd0);
        check("b.rst.pc_out",   b_if.pc_out, 32'h0000_0A00);
        tick();
        rst_n = 1'b1;
        #1;
        check("b.rst.instr_ready", 32'(b_if.instr_ready), 32'd1);
        tick();
        check("b.post.ex_valid", 32'(b_if.ex_valid), 32'd1);
        check("b.post.dest",     32'(b_if.dest), 32'd2);
        b_if.instr_valid = 1'b0;

        issue("clr", 32'h00A51820, 32'h300, 1'b1, mk(32'h00A51820, 32'h300, 32'd0, 32'd0, 5'd3, 8'h11, 1'b0));
        expect_out("clr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
